// File: rtl/lcd_cmd_host.sv
// Host-side command queue and IRB image-buffer sink for the LCD controller.
// Build option: define LCD_HOST_CHECKSUM_EN to include the frame_sum accumulator.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for controller not busy and a queued command
// ISSUE    | cmd_valid high for this single cycle
// ACK      | controller must show busy now, otherwise protocol error
// WAIT     | command in progress; done ends the session, !busy returns
// FINISHED | WRITE frame complete; queue flushed, only reset leaves
module lcd_cmd_host #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  host_cmd,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        done,
    input  logic        IRB_RW,
    input  logic [5:0]  IRB_A,
    input  logic [7:0]  IRB_D,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        frame_done,
    output logic [13:0] frame_sum,
    output logic        err_proto
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_WAIT,
        S_FINISHED
    } state_t;

    state_t        state;
    logic [2:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic [5:0]    exp_addr;
    logic [7:0]    cap_mem [64];
    logic          capture;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign host_ready = !full && (state != S_FINISHED);
    assign push       = host_valid && host_ready;
    assign pop        = (state == S_IDLE) && !busy && !empty;
    assign capture    = !IRB_RW;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= host_cmd;
        end
    end

    // Entering FINISHED drops anything still queued; host_ready keeps it empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == S_FINISHED) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd        <= 3'd0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            err_proto  <= 1'b0;
            exp_addr   <= 6'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cmd       <= fifo_mem[rd_ptr];
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_valid <= 1'b0;
                    state     <= S_ACK;
                end
                S_ACK: begin
                    if (busy) begin
                        state <= S_WAIT;
                    end else begin
                        err_proto <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        frame_done <= 1'b1;
                        state      <= S_FINISHED;
                    end else if (!busy) begin
                        state <= S_IDLE;
                    end
                end
                S_FINISHED: begin
                    state <= S_FINISHED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Out-of-order or unsolicited writes are flagged but still stored.
            if (capture) begin
                exp_addr <= exp_addr + 6'd1;
                if ((IRB_A != exp_addr) || (state != S_WAIT)) begin
                    err_proto <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            cap_mem[IRB_A] <= IRB_D;
        end
    end

    // Same-address read during a capture returns the previous byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= cap_mem[rd_addr];
        end
    end

`ifdef LCD_HOST_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_sum <= 14'd0;
        end else if (capture) begin
            frame_sum <= frame_sum + {6'd0, IRB_D};
        end
    end
`else
    assign frame_sum = 14'd0;
`endif

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host: table-driven push/readback vectors plus
// hand-written issue, protocol-error, frame-capture and mid-capture reset sequences.
module tb_lcd_cmd_host;

`ifdef LCD_HOST_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  host_cmd;
    logic        host_valid;
    logic        host_ready;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        done;
    logic        IRB_RW;
    logic [5:0]  IRB_A;
    logic [7:0]  IRB_D;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_done;
    logic [13:0] frame_sum;
    logic        err_proto;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] cmd;
        logic       ready_exp;
    } push_vec_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } rb_vec_t;

    push_vec_t push_tab[9];
    rb_vec_t   rb_tab[4];

    lcd_cmd_host #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .IRB_RW     (IRB_RW),
        .IRB_A      (IRB_A),
        .IRB_D      (IRB_D),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .err_proto  (err_proto)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 3'd0;
        busy       = 1'b0;
        done       = 1'b0;
        IRB_RW     = 1'b1;
        IRB_A      = 6'd0;
        IRB_D      = 8'd0;
        rd_addr    = 6'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [2:0] c);
        host_cmd   = c;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    // Controller model for one command: wait for the strobe, ack with busy or not.
    task automatic serve(input logic [2:0] exp_cmd, input bit ack, input string nm);
        int n = 0;
        while (!cmd_valid && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 32'(cmd_valid), 32'd1);
        chk({nm, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        if (ack) busy = 1'b1;
        tick();
        chk({nm, "_pulse_width"}, 32'(cmd_valid), 32'd0);
        tick();
        if (ack) begin
            busy = 1'b0;
            tick();
        end
    endtask

    task automatic start_write(input string nm);
        int n = 0;
        busy = 1'b0;
        push_one(3'd0);
        while (!cmd_valid && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 32'(cmd_valid), 32'd1);
        chk({nm, "_cmd"}, 32'(cmd), 32'd0);
        busy = 1'b1;
        tick();
        tick();
    endtask

    task automatic capture(input logic [5:0] a, input logic [7:0] d);
        IRB_RW = 1'b0;
        IRB_A  = a;
        IRB_D  = d;
        tick();
        IRB_RW = 1'b1;
    endtask

    task automatic count_issues(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cmd_valid) pulses++;
        end
    endtask

    initial begin
        int pulses;

        push_tab[0] = '{3'd1, 1'b1};
        push_tab[1] = '{3'd2, 1'b1};
        push_tab[2] = '{3'd3, 1'b1};
        push_tab[3] = '{3'd4, 1'b1};
        push_tab[4] = '{3'd5, 1'b1};
        push_tab[5] = '{3'd6, 1'b1};
        push_tab[6] = '{3'd7, 1'b1};
        push_tab[7] = '{3'd1, 1'b1};
        push_tab[8] = '{3'd2, 1'b0};

        rb_tab[0] = '{6'd10, 8'd10};
        rb_tab[1] = '{6'd0,  8'd0};
        rb_tab[2] = '{6'd63, 8'd63};
        rb_tab[3] = '{6'd33, 8'd33};

        // Reset state, observed while reset is still asserted.
        reset = 1'b1; host_valid = 1'b0; host_cmd = 3'd0; busy = 1'b0; done = 1'b0;
        IRB_RW = 1'b1; IRB_A = 6'd0; IRB_D = 8'd0; rd_addr = 6'd0;
        tick();
        tick();
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_sum", 32'(frame_sum), 32'd0);
        chk("rst_err", 32'(err_proto), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        reset = 1'b0;

        // Busy hold: UP queued, busy for 70 cycles, then one issue.
        busy = 1'b1;
        push_one(3'd1);
        count_issues(70, pulses);
        chk("hold_no_issue", 32'(pulses), 32'd0);
        busy = 1'b0;
        serve(3'd1, 1'b1, "hold_up");
        chk("hold_err", 32'(err_proto), 32'd0);
        count_issues(10, pulses);
        chk("hold_single", 32'(pulses), 32'd0);

        // FIFO fill past depth, then drain in order.
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("fill_ready_%0d", i), 32'(host_ready), 32'(push_tab[i].ready_exp));
            push_one(push_tab[i].cmd);
        end
        busy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (push_tab[i].ready_exp) serve(push_tab[i].cmd, 1'b1, $sformatf("order_%0d", i));
        end
        count_issues(12, pulses);
        chk("fill_ninth_dropped", 32'(pulses), 32'd0);
        chk("fill_err", 32'(err_proto), 32'd0);

        // Missing busy in ACK: error, next command still goes out.
        do_reset();
        busy = 1'b1;
        push_one(3'd3);
        push_one(3'd4);
        busy = 1'b0;
        serve(3'd3, 1'b0, "noack_left");
        chk("noack_err", 32'(err_proto), 32'd1);
        serve(3'd4, 1'b1, "noack_next");

        // Full WRITE frame with data = address.
        do_reset();
        start_write("wr");
        for (int a = 0; a < 64; a++) capture(6'(a), 8'(a));
        chk("wr_err", 32'(err_proto), 32'd0);
        chk("wr_frame_done_early", 32'(frame_done), 32'd0);
        done = 1'b1;
        tick();
        chk("wr_frame_done", 32'(frame_done), 32'd1);
        tick();
        chk("wr_frame_done_pulse", 32'(frame_done), 32'd0);
        chk("wr_frame_sum", 32'(frame_sum), (CSUM != 0) ? 32'd2016 : 32'd0);
        chk("wr_host_ready", 32'(host_ready), 32'd0);
        busy = 1'b0;
        host_cmd = 3'd2;
        host_valid = 1'b1;
        count_issues(10, pulses);
        host_valid = 1'b0;
        chk("wr_finished_silent", 32'(pulses), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = rb_tab[i].addr;
            tick();
            chk($sformatf("rb_%0d", rb_tab[i].addr), 32'(rd_data), 32'(rb_tab[i].data));
        end

        // Address skip 0,1,2,5.
        do_reset();
        start_write("skip");
        capture(6'd0, 8'hA0);
        capture(6'd1, 8'hA1);
        capture(6'd2, 8'hA2);
        chk("skip_err_before", 32'(err_proto), 32'd0);
        capture(6'd5, 8'h5C);
        chk("skip_err", 32'(err_proto), 32'd1);
        rd_addr = 6'd5;
        tick();
        chk("skip_mem5", 32'(rd_data), 32'h5C);

        // Reset in the middle of a capture at address 30.
        do_reset();
        start_write("mid");
        for (int a = 0; a < 30; a++) capture(6'(a), 8'd7);
        IRB_RW = 1'b0;
        IRB_A  = 6'd30;
        IRB_D  = 8'd7;
        reset  = 1'b1;
        tick();
        chk("mid_frame_sum", 32'(frame_sum), 32'd0);
        chk("mid_err", 32'(err_proto), 32'd0);
        chk("mid_host_ready", 32'(host_ready), 32'd1);
        chk("mid_cmd_valid", 32'(cmd_valid), 32'd0);
        IRB_RW = 1'b1;
        busy   = 1'b0;
        done   = 1'b0;
        reset  = 1'b0;
        count_issues(8, pulses);
        chk("mid_fifo_empty", 32'(pulses), 32'd0);
        start_write("mid_again");
        for (int a = 0; a < 64; a++) capture(6'(a), 8'(255 - a));
        chk("mid_again_err", 32'(err_proto), 32'd0);
        chk("mid_again_sum", 32'(frame_sum), (CSUM != 0) ? 32'd14304 : 32'd0);
        rd_addr = 6'd30;
        tick();
        chk("mid_again_rb30", 32'(rd_data), 32'd225);
        rd_addr = 6'd0;
        tick();
        chk("mid_again_rb0", 32'(rd_data), 32'd255);
        done = 1'b1;
        tick();
        chk("mid_again_frame_done", 32'(frame_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_host.md
# lcd_cmd_host

Host-side counterpart of the LCD controller. It queues 3-bit commands from a test/system master and issues them to the controller over the `cmd`/`cmd_valid`/`busy` handshake. It also acts as the IRB image-buffer sink: it captures the 64 bytes the controller writes during a WRITE command and exposes them for readback with a frame checksum. It sits between the system master and the controller, on the opposite end of both the command port and the IRB port.

## Interface
- `DEPTH`, 8: command FIFO depth; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `host_cmd`  in  3  command to enqueue (0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 AVERAGE, 6 MIRROR_X, 7 MIRROR_Y).
- `host_valid`  in  1  enqueue request.
- `host_ready`  out  1  combinational: FIFO not full and state ≠ FINISHED.
- `cmd`  out  3  registered command to controller.
- `cmd_valid`  out  1  registered single-cycle command strobe.
- `busy`  in  1  controller busy.
- `done`  in  1  controller done (sticky high after WRITE completes).
- `IRB_RW`  in  1  controller write strobe, active low.
- `IRB_A`  in  6  controller write address.
- `IRB_D`  in  8  controller write data.
- `rd_addr`  in  6  capture-buffer readback address.
- `rd_data`  out  8  readback data, registered.
- `frame_done`  out  1  one-cycle pulse when the WRITE frame completes.
- `frame_sum`  out  14  sum of captured bytes.
- `err_proto`  out  1  sticky protocol-error flag.

## Operation
- Reset values: `cmd`=0, `cmd_valid`=0, `rd_data`=0, `frame_done`=0, `frame_sum`=0, `err_proto`=0. FIFO is empty, state is IDLE, expected-address counter is 0. Capture memory is not reset.
- FIFO: a push occurs when `host_valid && host_ready`. A pop occurs on the IDLE→ISSUE transition. FIFO order is preserved. A push to a full FIFO is impossible because `host_ready` is low.
- FSM:
  - IDLE: if `!busy && !empty`, pop the head into `cmd`, set `cmd_valid`=1, go to ISSUE.
  - ISSUE: lasts one cycle; drop `cmd_valid`; go to ACK.
  - ACK: if `busy`=1, go to WAIT. If `busy`=0, set `err_proto`=1 and go to IDLE; the command is lost.
  - WAIT: if `done`=1, go to FINISHED. Otherwise, if `busy`=0, go to IDLE.
  - FINISHED: pulse `frame_done` on entry, flush the FIFO, issue nothing further. Only reset exits this state.
- `busy` high from the controller (for example, during image load) holds IDLE indefinitely. No timeout.
- Capture: on any cycle with `IRB_RW`=0, write `mem[IRB_A]` <= `IRB_D`, add `IRB_D` to `frame_sum`, and advance the expected-address counter modulo 64.
  - If `IRB_A` ≠ the expected address, set `err_proto`=1. The write still occurs.
  - A capture while state ≠ WAIT also sets `err_proto`.
- `frame_sum` is 14-bit and wraps modulo 2^14 only on duplicate frames. 64×255 = 16320 fits.
- Readback: `rd_data` <= `mem[rd_addr]` every cycle.
- A read and a capture to the same address in the same cycle return the old data.
- Reset mid-operation (any state, including mid-capture) restores all reset values on the next edge.

## Timing
- Command issue latency: `cmd_valid` rises one cycle after the IDLE cycle that sees `!busy && !empty`. It is high for exactly one cycle.
- Minimum command-to-command spacing is 4 cycles (IDLE, ISSUE, ACK, WAIT).
- `busy` must be high in the ACK cycle, i.e. the cycle after `cmd_valid`.
- `host_ready` reflects pops in the same cycle only after the registered state update; no same-cycle bypass.
- `frame_done` asserts the cycle after WAIT samples `done`=1.
- `rd_data` has a latency of 1 cycle.

## Configuration
- `LCD_HOST_CHECKSUM_EN` defined: `frame_sum` accumulator is present as described above.
- Not defined: no accumulator is synthesized and `frame_sum` is tied to 0. Capture, readback, and address checking are unchanged.

## Test plan
- Reset, FIFO holds UP, `busy`=1 for 70 cycles -> `cmd_valid` stays 0; when `busy` falls, a single pulse with `cmd`=1 occurs and `err_proto`=0.
- `busy` held 1, push DEPTH+1=9 commands 1..7,1,2 -> `host_ready` low after 8 pushes and the 9th is not accepted; after release, commands issue in order 1,2,…,7,1.
- Issue LEFT, controller model keeps `busy`=0 in ACK -> `err_proto`=1, and the next queued command still issues.
- WRITE: model writes `IRB_A`=0..63 with `IRB_D`=A, then asserts `done` -> one `frame_done` pulse, `frame_sum`=2016, `host_ready`=0; `rd_addr`=10 gives `rd_data`=10 one cycle later.
- Capture sequence with addresses 0,1,2,5 -> `err_proto`=1, and `mem[5]` holds the written data.
- Reset asserted mid-capture at address 30 -> next cycle `frame_sum`=0, `err_proto`=0, FIFO empty, and a new WRITE captures correctly from address 0.
